// File: rtl/ibex_dmem_responder.sv
// ibex_dmem_responder
// Memory-side responder for the Ibex LSU data port (req/gnt/rvalid).
// It models a word-addressed SRAM with these features:
//   - a programmable grant delay,
//   - a fixed response latency,
//   - a bounded number of outstanding transactions,
//   - error responses for misaligned or out-of-range accesses.
// Responses travel down a shift register of RspLatency stages. The last stage
// drives the output ports directly, so rvalid/rdata/err are registered.
module ibex_dmem_responder #(
    parameter int          MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int          GntDelay       = 0,
    parameter int          RspLatency     = 1,
    parameter int          MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        stall_i
);

    localparam int          IdxW    = $clog2(MemWords);
    localparam logic [32:0] EndAddr = {1'b0, BaseAddr} + (33'(MemWords) * 33'd4);

    logic [3:0]                  dly_cnt;
    logic                        slot_free;
    logic                        accept;
    logic [31:0]                 outstanding;

    logic                        addr_err;
    logic [IdxW+1:0]             offset;
    logic [IdxW-1:0]             word_idx;
    logic [31:0]                 rd_word;
    logic [31:0]                 rsp_data;

    logic [RspLatency-1:0]       pipe_vld;
    logic [RspLatency-1:0]       pipe_err;
    logic [RspLatency-1:0][31:0] pipe_data;

    logic [31:0]                 mem [MemWords];

    // Grant is purely combinational so the LSU sees it in the request cycle.
    assign data_gnt_o = data_req_i & (dly_cnt == 4'(GntDelay)) & ~stall_i
                        & slot_free & ~rst_i;
    assign accept     = data_req_i & data_gnt_o;

    // Address decode for the current request.
    // BaseAddr is aligned to the memory size, so only the low bits of the
    // offset are needed to form the word index.
    assign addr_err = (data_addr_i[1:0] != 2'b00)
                      | ({1'b0, data_addr_i} < {1'b0, BaseAddr})
                      | ({1'b0, data_addr_i} >= EndAddr);
    assign offset   = data_addr_i[IdxW+1:0] - BaseAddr[IdxW+1:0];
    assign word_idx = offset[IdxW+1:2];
    assign rd_word  = mem[word_idx];
    assign rsp_data = (data_we_i | addr_err) ? 32'h0 : rd_word;

    // Count occupied pipeline stages.
    // The stage on the output is leaving this cycle, so it does not count,
    // and its slot is free again in the same cycle.
    always_comb begin
        outstanding = 32'h0;
        for (int k = 0; k < RspLatency - 1; k++) begin
            outstanding = outstanding + 32'(pipe_vld[k]);
        end
        slot_free = (outstanding < 32'(MaxOutstanding));
    end

    // Grant-delay counter.
    // It counts request-held cycles up to GntDelay. It clears on a grant or
    // when the request drops. A stall does not clear it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dly_cnt <= 4'd0;
        end else if (!data_req_i || data_gnt_o) begin
            dly_cnt <= 4'd0;
        end else if (dly_cnt != 4'(GntDelay)) begin
            dly_cnt <= dly_cnt + 4'd1;
        end
    end

    // SRAM write port: byte-masked, only for accepted, error-free writes.
    // Memory contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (accept && data_we_i && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline.
    // Empty stages carry zero data and zero err, so the outputs read zero
    // whenever rvalid is low. Reset drops every in-flight response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld  <= '0;
            pipe_err  <= '0;
            pipe_data <= '0;
        end else begin
            pipe_vld[0]  <= accept;
            pipe_err[0]  <= accept & addr_err;
            pipe_data[0] <= accept ? rsp_data : 32'h0;
            for (int k = 1; k < RspLatency; k++) begin
                pipe_vld[k]  <= pipe_vld[k-1];
                pipe_err[k]  <= pipe_err[k-1];
                pipe_data[k] <= pipe_data[k-1];
            end
        end
    end

    assign data_rvalid_o = pipe_vld[RspLatency-1];
    assign data_err_o    = pipe_err[RspLatency-1];
    assign data_rdata_o  = pipe_data[RspLatency-1];

endmodule

// File: tb/tb_ibex_dmem_responder.sv
// Testbench for ibex_dmem_responder.
// It drives four instances with different grant-delay, latency and
// outstanding settings, using one instance at a time. A scoreboard queue
// holds each expected response and its due cycle.
module tb_ibex_dmem_responder;

    localparam int GD[4] = '{0, 2, 0, 0};
    localparam int RL[4] = '{1, 1, 4, 3};
    localparam int MO[4] = '{2, 2, 2, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst    [4];
    logic        req    [4];
    logic        gnt    [4];
    logic        we     [4];
    logic        stall  [4];
    logic        rvalid [4];
    logic        err    [4];
    logic [31:0] addr   [4];
    logic [31:0] wdata  [4];
    logic [31:0] rdata  [4];
    logic [3:0]  be     [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ibex_dmem_responder #(
            .MemWords      (1024),
            .BaseAddr      (32'h0000_0000),
            .GntDelay      (GD[g]),
            .RspLatency    (RL[g]),
            .MaxOutstanding(MO[g])
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst[g]),
            .data_req_i   (req[g]),
            .data_gnt_o   (gnt[g]),
            .data_addr_i  (addr[g]),
            .data_we_i    (we[g]),
            .data_be_i    (be[g]),
            .data_wdata_i (wdata[g]),
            .data_rvalid_o(rvalid[g]),
            .data_rdata_o (rdata[g]),
            .data_err_o   (err[g]),
            .stall_i      (stall[g])
        );
    end

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          act = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rv_seen = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;
    logic [31:0] mdl [4][1024];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Response monitor for the active instance.
    always @(negedge clk) begin
        if (rvalid[act]) begin
            rv_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(mon_e.due));
                chk("rsp_err", 64'(err[act]), 64'(mon_e.err));
                chk("rsp_rdata", 64'(rdata[act]), 64'(mon_e.data));
                last_rdata = rdata[act];
                last_err   = err[act];
            end
        end else begin
            chk("idle_zero", 64'({err[act], rdata[act]}), 64'd0);
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                chk("missing_rsp", 64'd0, 64'd1);
                void'(sb.pop_front());
            end
        end
    end

    // Hold a request until it is granted, then push the expected response.
    // The task returns at #1 after the accept edge and leaves req high, so
    // callers can issue back to back.
    task automatic issue(input int i, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, output int gc);
        int   lat;
        int   idx;
        logic e;
        lat      = RL[i];
        gc       = -1;
        req[i]   = 1'b1;
        we[i]    = w;
        addr[i]  = a;
        be[i]    = b;
        wdata[i] = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (gnt[i]) begin
                gc  = cyc;
                e   = (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
                idx = int'(a[11:2]);
                if (e) begin
                    sb.push_back('{cyc + lat, 1'b1, 32'h0});
                end else if (w) begin
                    for (int k = 0; k < 4; k++) begin
                        if (b[k]) mdl[i][idx][8*k +: 8] = d[8*k +: 8];
                    end
                    sb.push_back('{cyc + lat, 1'b0, 32'h0});
                end else begin
                    sb.push_back('{cyc + lat, 1'b0, mdl[i][idx]});
                end
                break;
            end
        end
        @(posedge clk);
        #1;
        if (gc < 0) chk("gnt_timeout", 64'd0, 64'd1);
    endtask

    // Drop the request and wait for every expected response to come out.
    task automatic idle(input int i);
        req[i] = 1'b0;
        we[i]  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] err_addr [3] = '{32'h0000_0002, 32'h0000_1000, 32'h0000_1003};
    logic        err_we   [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        int g0, g1, g2, c, rel;
        for (int i = 0; i < 4; i++) begin
            rst[i]   = 1'b1;
            req[i]   = 1'b0;
            we[i]    = 1'b0;
            addr[i]  = 32'h0;
            be[i]    = 4'h0;
            wdata[i] = 32'h0;
            stall[i] = 1'b0;
        end

        // Reset held with a pending request: no grant and no response.
        act      = 0;
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 32'h10;
        be[0]    = 4'hF;
        wdata[0] = 32'hDEADBEEF;
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", 64'(gnt[0]), 64'd0);
            chk("rst_rvalid", 64'(rvalid[0]), 64'd0);
            chk("rst_rdata", 64'(rdata[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        rel = cyc;

        // Write then read back to back, latency 1.
        issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, g0);
        chk("rst_first_gnt", 64'(g0), 64'(rel));
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0, g1);
        chk("b2b_gnt", 64'(g1), 64'(g0 + 1));
        idle(0);
        chk("rd_deadbeef", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);

        // Single-byte write merges into the existing word.
        issue(0, 1'b1, 32'h10, 4'b0001, 32'h0000_00AA, g0);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0, g1);
        idle(0);
        chk("rd_beaa", 64'(last_rdata), 64'h0000_0000_DEAD_BEAA);

        // Error cases: err=1 and rdata=0, and memory is left untouched.
        for (int k = 0; k < 3; k++) begin
            issue(0, err_we[k], err_addr[k], 4'hF, 32'h5555_5555, g0);
            idle(0);
            chk("err_flag", 64'(last_err), 64'd1);
            chk("err_rdata", 64'(last_rdata), 64'd0);
            issue(0, 1'b0, 32'h10, 4'h0, 32'h0, g0);
            idle(0);
            chk("err_mem_kept", 64'(last_rdata), 64'h0000_0000_DEAD_BEAA);
        end

        // A write with be=0 is legal and leaves memory unchanged.
        issue(0, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, g0);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0, g1);
        idle(0);
        chk("be0_kept", 64'(last_rdata), 64'h0000_0000_DEAD_BEAA);

        // GntDelay=2: grant comes in the third cycle of the request.
        act = 1;
        c = cyc;
        issue(1, 1'b1, 32'h20, 4'hF, 32'h1111_2222, g0);
        chk("gd_gnt", 64'(g0 - c), 64'd2);
        idle(1);

        // Stall on request cycles 2-4: grant comes as soon as stall drops.
        c = cyc;
        fork
            issue(1, 1'b0, 32'h20, 4'h0, 32'h0, g0);
            begin
                @(posedge clk);
                #1 stall[1] = 1'b1;
                repeat (3) @(posedge clk);
                #1 stall[1] = 1'b0;
            end
        join
        chk("stall_gnt", 64'(g0 - c), 64'd4);
        idle(1);
        chk("stall_rdata", 64'(last_rdata), 64'h0000_0000_1111_2222);

        // RspLatency=4, MaxOutstanding=2: the third read waits for a free slot.
        act = 2;
        issue(2, 1'b1, 32'h0, 4'hF, 32'hA000_0000, g0);
        issue(2, 1'b1, 32'h4, 4'hF, 32'hA000_0004, g0);
        issue(2, 1'b1, 32'h8, 4'hF, 32'hA000_0008, g0);
        idle(2);
        issue(2, 1'b0, 32'h0, 4'h0, 32'h0, g0);
        issue(2, 1'b0, 32'h4, 4'h0, 32'h0, g1);
        issue(2, 1'b0, 32'h8, 4'h0, 32'h0, g2);
        idle(2);
        chk("os_gnt1", 64'(g1 - g0), 64'd1);
        chk("os_gnt2", 64'(g2 - g0), 64'd4);
        chk("os_last", 64'(last_rdata), 64'h0000_0000_A000_0008);

        // Reset one cycle after an accept flushes the in-flight response.
        act = 3;
        issue(3, 1'b1, 32'h10, 4'hF, 32'h1234_5678, g0);
        idle(3);
        issue(3, 1'b0, 32'h10, 4'h0, 32'h0, g0);
        req[3] = 1'b0;
        rst[3] = 1'b1;
        sb.delete();
        rv_seen = 0;
        @(posedge clk);
        #1 rst[3] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_flush", 64'(rv_seen), 64'd0);
        issue(3, 1'b0, 32'h10, 4'h0, 32'h0, g0);
        idle(3);
        chk("post_rst_rd", 64'(last_rdata), 64'h0000_0000_1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        chk("watchdog", 64'd0, 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
